wb_port_arbiter: RTL and testbench

Shares the single register-file write port of the write-back stage between two producers. Requester A is the in-order main pipeline (memory-stage output). Requester B is the multi-cycle mul/div unit. The block also keeps a busy-register scoreboard for B's outstanding destinations, which decode uses for hazard stalls. Its registered output drives the write-back stage's valid/inst_id/rf_wen/reg_addr/wdata inputs directly.

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 tb/tb_wb_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register-file write port between the main pipeline (A)
// and the mul/div unit (B), with starvation relief for B and a busy scoreboard for B's dests.
module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int XLEN         = 32,
   parameter int IID_W        = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [IID_W-1:0] a_inst_id,
   input  logic             a_rf_wen,
   input  logic [4:0]       a_reg_addr,
   input  logic [XLEN-1:0]  a_wdata,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [IID_W-1:0] b_inst_id,
   input  logic             b_rf_wen,
   input  logic [4:0]       b_reg_addr,
   input  logic [XLEN-1:0]  b_wdata,
   input  logic             issue_valid,
   input  logic [4:0]       issue_reg_addr,
   output logic             wb_valid,
   output logic [IID_W-1:0] wb_inst_id,
   output logic             wb_rf_wen,
   output logic [4:0]       wb_reg_addr,
   output logic [XLEN-1:0]  wb_wdata,
   output logic [31:0]      busy,
   output logic [3:0]       wait_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic        starve;
   logic        grant_a;
   logic        grant_b;
   logic [31:0] busy_next;

   // Handshake: a transfer happens on x_valid & x_ready; a stalled requester holds its fields.
   // Ready is a function of the valids and wait_cnt only, never of the other ready.
   always_comb begin
      starve  = (wait_cnt >= LIMIT);
      grant_b = b_valid & (~a_valid | starve);
      grant_a = a_valid & ~grant_b;
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (~b_valid | grant_b) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'hF) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Set is applied after clear so that a same-cycle set on the same register wins.
   always_comb begin
      busy_next = busy;
      if (grant_b & b_rf_wen) begin
         busy_next[b_reg_addr] = 1'b0;
      end
      if (issue_valid && (issue_reg_addr != 5'd0)) begin
         busy_next[issue_reg_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 32'd0;
      end else begin
         busy <= busy_next;
      end
   end

   // Fields keep their last value when nothing is granted; only wb_valid drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_valid    <= 1'b0;
         wb_inst_id  <= '0;
         wb_rf_wen   <= 1'b0;
         wb_reg_addr <= 5'd0;
         wb_wdata    <= '0;
      end else begin
         wb_valid <= grant_a | grant_b;
         if (grant_a) begin
            wb_inst_id  <= a_inst_id;
            wb_rf_wen   <= a_rf_wen;
            wb_reg_addr <= a_reg_addr;
            wb_wdata    <= a_wdata;
         end else if (grant_b) begin
            wb_inst_id  <= b_inst_id;
            wb_rf_wen   <= b_rf_wen;
            wb_reg_addr <= b_reg_addr;
            wb_wdata    <= b_wdata;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed steps with a reference grant/scoreboard model and an
// expected-entry queue checked against every write-back output.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;
   localparam int XLEN  = 32;
   localparam int IID_W = 64;
   localparam int EW    = IID_W + 1 + 5 + XLEN;

   logic             clk = 1'b0;
   logic             reset;
   logic             a_valid, a_ready, a_rf_wen;
   logic [IID_W-1:0] a_inst_id;
   logic [4:0]       a_reg_addr;
   logic [XLEN-1:0]  a_wdata;
   logic             b_valid, b_ready, b_rf_wen;
   logic [IID_W-1:0] b_inst_id;
   logic [4:0]       b_reg_addr;
   logic [XLEN-1:0]  b_wdata;
   logic             issue_valid;
   logic [4:0]       issue_reg_addr;
   logic             wb_valid, wb_rf_wen;
   logic [IID_W-1:0] wb_inst_id;
   logic [4:0]       wb_reg_addr;
   logic [XLEN-1:0]  wb_wdata;
   logic [31:0]      busy;
   logic [3:0]       wait_cnt;

   logic [EW-1:0] exp_q[$];
   logic [3:0]    wc_m;
   logic [31:0]   busy_m;
   int            errors = 0;
   int            checks = 0;
   int            wb_seen = 0;

   // clock / reset
   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(XLEN), .IID_W(IID_W)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_inst_id(a_inst_id), .a_rf_wen(a_rf_wen),
      .a_reg_addr(a_reg_addr), .a_wdata(a_wdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_inst_id(b_inst_id), .b_rf_wen(b_rf_wen),
      .b_reg_addr(b_reg_addr), .b_wdata(b_wdata),
      .issue_valid(issue_valid), .issue_reg_addr(issue_reg_addr),
      .wb_valid(wb_valid), .wb_inst_id(wb_inst_id), .wb_rf_wen(wb_rf_wen),
      .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata), .busy(busy), .wait_cnt(wait_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic set_a(input logic v, input logic [IID_W-1:0] id, input logic wen,
                        input logic [4:0] addr, input logic [XLEN-1:0] data);
      a_valid = v; a_inst_id = id; a_rf_wen = wen; a_reg_addr = addr; a_wdata = data;
   endtask

   task automatic set_b(input logic v, input logic [IID_W-1:0] id, input logic wen,
                        input logic [4:0] addr, input logic [XLEN-1:0] data);
      b_valid = v; b_inst_id = id; b_rf_wen = wen; b_reg_addr = addr; b_wdata = data;
   endtask

   task automatic set_issue(input logic v, input logic [4:0] addr);
      issue_valid = v; issue_reg_addr = addr;
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
   endtask

   // One clock: sample at negedge, score outputs, advance model, return 1 time unit after posedge.
   task automatic cycle(output logic ga, output logic gb);
      logic [EW-1:0] e;
      logic exp_ga, exp_gb;
      @(negedge clk);
      if (wb_valid) begin
         wb_seen++;
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {127'd0, wb_valid}, 128'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_entry", {26'd0, wb_inst_id, wb_rf_wen, wb_reg_addr, wb_wdata}, {26'd0, e});
         end
      end
      exp_gb = b_valid && (!a_valid || (wc_m >= 4'(LIMIT)));
      exp_ga = a_valid && !exp_gb;
      chk("a_ready", {127'd0, a_ready}, {127'd0, exp_ga});
      chk("b_ready", {127'd0, b_ready}, {127'd0, exp_gb});
      chk("ready_excl", {127'd0, a_ready & b_ready}, 128'd0);
      chk("wait_cnt", {124'd0, wait_cnt}, {124'd0, wc_m});
      chk("busy", {96'd0, busy}, {96'd0, busy_m});
      if (exp_ga) exp_q.push_back({a_inst_id, a_rf_wen, a_reg_addr, a_wdata});
      if (exp_gb) exp_q.push_back({b_inst_id, b_rf_wen, b_reg_addr, b_wdata});
      if (!b_valid || exp_gb) wc_m = 4'd0;
      else if (wc_m != 4'hF) wc_m = wc_m + 4'd1;
      if (exp_gb && b_rf_wen) busy_m[b_reg_addr] = 1'b0;
      if (issue_valid && issue_reg_addr != 5'd0) busy_m[issue_reg_addr] = 1'b1;
      ga = a_ready;
      gb = b_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic ga, gb;
      reset = 1'b1;
      idle();
      set_a(1'b0, '0, 1'b0, 5'd0, '0);
      set_b(1'b0, '0, 1'b0, 5'd0, '0);
      set_issue(1'b0, 5'd0);
      wc_m = 4'd0;
      busy_m = 32'd0;
      #12;
      chk("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
      chk("rst_wb_inst_id", {64'd0, wb_inst_id}, 128'd0);
      chk("rst_wb_fields", {90'd0, wb_rf_wen, wb_reg_addr, wb_wdata}, 128'd0);
      chk("rst_busy", {96'd0, busy}, 128'd0);
      chk("rst_readies", {126'd0, a_ready, b_ready}, 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // A only
      set_a(1'b1, 64'd1, 1'b1, 5'd5, 32'h1234);
      cycle(ga, gb);
      idle();
      chk("a_only_wb_valid", {127'd0, wb_valid}, 128'd1);
      chk("a_only_wb_addr", {123'd0, wb_reg_addr}, 128'd5);
      chk("a_only_wb_data", {96'd0, wb_wdata}, 128'h1234);
      cycle(ga, gb);
      chk("a_only_drop", {127'd0, wb_valid}, 128'd0);

      // B alone plus scoreboard
      set_issue(1'b1, 5'd7);
      cycle(ga, gb);
      set_issue(1'b0, 5'd0);
      chk("sb_set7", {127'd0, busy[7]}, 128'd1);
      cycle(ga, gb);
      cycle(ga, gb);
      set_b(1'b1, 64'd2, 1'b1, 5'd7, $urandom);
      cycle(ga, gb);
      b_valid = 1'b0;
      chk("sb_clr7", {127'd0, busy[7]}, 128'd0);
      chk("b_wb_addr", {123'd0, wb_reg_addr}, 128'd7);
      cycle(ga, gb);

      // Starvation: B waits LIMIT cycles, wins once, then A resumes
      set_a(1'b1, 64'd100, 1'b1, 5'd3, $urandom);
      set_b(1'b1, 64'd200, 1'b1, 5'd12, $urandom);
      for (int i = 0; i < 6; i++) begin
         cycle(ga, gb);
         if (i < LIMIT) chk("starve_a_grant", {126'd0, ga, gb}, 128'b10);
         if (i == LIMIT) chk("starve_b_grant", {126'd0, ga, gb}, 128'b01);
         if (i == LIMIT + 1) chk("starve_a_again", {126'd0, ga, gb}, 128'b10);
         if (i == LIMIT) chk("starve_wb_b", {64'd0, wb_inst_id}, 128'd200);
         if (ga) set_a(1'b1, 64'(101 + i), 1'b1, 5'(i + 1), $urandom);
         if (gb) b_valid = 1'b0;
      end
      idle();
      cycle(ga, gb);

      // Same-cycle set/clear, then issue to x0
      set_issue(1'b1, 5'd9);
      cycle(ga, gb);
      set_b(1'b1, 64'd300, 1'b1, 5'd9, $urandom);
      cycle(ga, gb);
      idle();
      chk("sb_set_wins", {127'd0, busy[9]}, 128'd1);
      set_b(1'b1, 64'd301, 1'b1, 5'd9, $urandom);
      cycle(ga, gb);
      idle();
      chk("sb_clr9", {127'd0, busy[9]}, 128'd0);
      set_issue(1'b1, 5'd0);
      cycle(ga, gb);
      idle();
      chk("sb_x0", {96'd0, busy}, 128'd0);

      // Back-to-back alternation, B in even slots and A in odd slots
      wb_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            a_valid = 1'b0;
            set_b(1'b1, 64'(400 + i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         end else begin
            b_valid = 1'b0;
            set_a(1'b1, 64'(400 + i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         end
         cycle(ga, gb);
      end
      idle();
      cycle(ga, gb);
      chk("alt_count", 128'(wb_seen), 128'd20);

      // Asynchronous reset in the middle of traffic
      set_a(1'b1, 64'd500, 1'b1, 5'd4, $urandom);
      set_b(1'b1, 64'd501, 1'b1, 5'd6, $urandom);
      set_issue(1'b1, 5'd3);
      cycle(ga, gb);
      set_issue(1'b0, 5'd0);
      set_a(1'b1, 64'd502, 1'b1, 5'd4, $urandom);
      cycle(ga, gb);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_wb_valid", {127'd0, wb_valid}, 128'd0);
      chk("mid_rst_busy", {96'd0, busy}, 128'd0);
      chk("mid_rst_wait_cnt", {124'd0, wait_cnt}, 128'd0);
      idle();
      exp_q.delete();
      wc_m = 4'd0;
      busy_m = 32'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      set_a(1'b1, 64'd600, 1'b1, 5'd8, $urandom);
      set_b(1'b1, 64'd601, 1'b1, 5'd10, $urandom);
      cycle(ga, gb);
      chk("cold_start_grant", {126'd0, ga, gb}, 128'b10);
      idle();
      cycle(ga, gb);
      cycle(ga, gb);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
